// File: rtl/load_store_unit_split_pkg.sv
`default_nettype none
// ============================================================================
// load_store_unit_split_pkg : opcodes, funct3 encodings and LSU state encoding
// Rev 1.0
// ============================================================================
package load_store_unit_split_pkg;

  localparam logic [6:0] c_LOAD  = 7'b0000011;
  localparam logic [6:0] c_STORE = 7'b0100011;

  localparam logic [2:0] c_BYTE              = 3'b000;
  localparam logic [2:0] c_HALFWORD          = 3'b001;
  localparam logic [2:0] c_WORD              = 3'b010;
  localparam logic [2:0] c_DOUBLEWORD        = 3'b011;
  localparam logic [2:0] c_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] c_HALFWORD_UNSIGNED = 3'b101;
  localparam logic [2:0] c_WORD_UNSIGNED     = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Access size in bytes; 0 marks an encoding with no size.
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    case (f3)
      c_BYTE, c_BYTE_UNSIGNED:         f3_size = 4'd1;
      c_HALFWORD, c_HALFWORD_UNSIGNED: f3_size = 4'd2;
      c_WORD, c_WORD_UNSIGNED:         f3_size = 4'd4;
      c_DOUBLEWORD:                    f3_size = 4'd8;
      default:                         f3_size = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_split_lane_mapper.sv
`default_nettype none
// ============================================================================
// lsu_lane_mapper : byte-lane mask and rotated store data for one bus beat
// Rev 1.0
// ============================================================================
module lsu_lane_mapper #(
  parameter  int DATA_WIDTH = 32,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int OFS        = $clog2(LANES)
) (
  input  logic [OFS-1:0]        i_off,
  input  logic [3:0]            i_sz,
  input  logic                  i_beat,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  output logic [LANES-1:0]      o_mask,
  output logic [DATA_WIDTH-1:0] o_wdata
);

  // Lane i carries access byte (i - off) mod LANES; beat 0 owns lanes at or
  // above off, beat 1 owns the wrapped lanes below off.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [OFS-1:0] c_lane = OFS'(i);
    logic [OFS-1:0] w_k;
    logic           w_in_beat;

    assign w_k       = c_lane - i_off;
    assign w_in_beat = i_beat ? (c_lane < i_off) : (c_lane >= i_off);
    assign o_mask[i] = w_in_beat && (4'(w_k) < i_sz);
    assign o_wdata[8*i +: 8] = o_mask[i] ? i_store_data[{w_k, 3'b000} +: 8] : 8'h00;
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit_split.sv
`default_nettype none
// ============================================================================
// load_store_unit_split : sequential load/store unit, splits word-crossing accesses
// Rev 1.0
// ============================================================================
module load_store_unit_split
  import load_store_unit_split_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [6:0]                req_opcode,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_address,
  input  logic [DATA_WIDTH-1:0]     req_store_data,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_load_data,
  output logic                      resp_fault,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_write,
  output logic [ADDR_WIDTH-1:0]     mem_address,
  output logic [DATA_WIDTH/8-1:0]   mem_frame_mask,
  output logic [DATA_WIDTH-1:0]     mem_write_data,
  input  logic [DATA_WIDTH-1:0]     mem_read_data
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(LANES);

  lsu_state_e            r_state, w_state_nxt;
  logic                  r_write, r_unsigned, r_fault;
  logic [3:0]            r_sz;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_sdata;
  logic [7:0]            r_buf [LANES];

  logic [3:0]            w_req_sz;
  logic [OFS-1:0]        w_req_off, w_off, w_msb;
  logic                  w_req_illegal, w_req_misal, w_req_fault, w_accept;
  logic                  w_cross, w_beat1, w_mem_valid, w_beat_done, w_sign;
  logic [LANES-1:0]      w_mask, w_mask_rot;
  logic [DATA_WIDTH-1:0] w_wdata, w_rd_rot, w_load;

  assign w_req_sz      = f3_size(req_funct3);
  assign w_req_off     = req_address[OFS-1:0];
  assign w_req_illegal = !(req_opcode == c_LOAD || req_opcode == c_STORE) ||
                         (w_req_sz == 4'd0) || (int'(w_req_sz) > LANES) ||
                         (req_funct3 == c_WORD_UNSIGNED && LANES != 8);
  assign w_req_misal   = (4'(w_req_off) & (w_req_sz - 4'd1)) != 4'd0;
  assign w_req_fault   = w_req_illegal || (w_req_misal && !ALLOW_MISALIGNED);
  assign w_accept      = (r_state == IDLE) && req_valid;

  assign w_off       = r_addr[OFS-1:0];
  assign w_cross     = (int'(w_off) + int'(r_sz)) > LANES;
  assign w_beat1     = (r_state == BEAT1);
  assign w_mem_valid = (r_state == BEAT0) || w_beat1;
  assign w_beat_done = w_mem_valid && mem_ready;

  lsu_lane_mapper #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mapper (
    .i_off        (w_off),
    .i_sz         (r_sz),
    .i_beat       (w_beat1),
    .i_store_data (r_sdata),
    .o_mask       (w_mask),
    .o_wdata      (w_wdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = w_req_fault ? RESP : BEAT0;
      BEAT0:   if (mem_ready) w_state_nxt = w_cross ? BEAT1 : RESP;
      BEAT1:   if (mem_ready) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_fault    <= 1'b0;
      r_sz       <= '0;
      r_addr     <= '0;
      r_sdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write    <= (req_opcode == c_STORE);
        r_unsigned <= req_funct3[2];
        r_fault    <= w_req_fault;
        r_sz       <= w_req_sz;
        r_addr     <= req_address;
        r_sdata    <= req_store_data;
      end
    end
  end

  // Rotate the bus word so access byte k sits at position k.
  always_comb begin
    logic [OFS-1:0] w_lane;
    w_rd_rot   = '0;
    w_mask_rot = '0;
    w_lane     = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane             = w_off + OFS'(k);
      w_rd_rot[8*k +: 8] = mem_read_data[{w_lane, 3'b000} +: 8];
      w_mask_rot[k]      = w_mask[w_lane];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) r_buf[k] <= 8'h00;
    end else if (w_beat_done) begin
      for (int k = 0; k < LANES; k++)
        if (w_mask_rot[k]) r_buf[k] <= w_rd_rot[8*k +: 8];
    end
  end

  assign w_msb  = OFS'(r_sz - 4'd1);
  assign w_sign = !r_unsigned && r_buf[w_msb][7];

  always_comb begin
    w_load = '0;
    for (int k = 0; k < LANES; k++)
      w_load[8*k +: 8] = (k < int'(r_sz)) ? r_buf[k] : {8{w_sign}};
  end

  assign req_ready      = (r_state == IDLE);
  assign mem_valid      = w_mem_valid;
  assign mem_write      = w_mem_valid && r_write;
  assign mem_address    = w_mem_valid ?
                          ({r_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}} +
                           (w_beat1 ? ADDR_WIDTH'(LANES) : '0)) : '0;
  assign mem_frame_mask = w_mem_valid ? w_mask : '0;
  assign mem_write_data = (w_mem_valid && r_write) ? w_wdata : '0;
  assign resp_valid     = (r_state == RESP);
  assign resp_fault     = resp_valid && r_fault;
  assign resp_load_data = (resp_valid && !r_write && !r_fault) ? w_load : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit_split.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit_split : scoreboard bench for the split load/store unit
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit_split;
  import load_store_unit_split_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic [6:0]  req_opcode = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_address = '0, req_store_data = '0;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_read_data = '0;

  logic        req_ready, resp_valid, resp_fault, mem_valid, mem_write;
  logic [31:0] resp_load_data, mem_address, mem_write_data;
  logic [3:0]  mem_frame_mask;
  logic        req_ready2, resp_valid2, resp_fault2, mem_valid2, mem_write2;
  logic [31:0] resp_load_data2, mem_address2, mem_write_data2;
  logic [3:0]  mem_frame_mask2;

  always #5 clk = ~clk;

  load_store_unit_split #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_address(req_address),
    .req_store_data(req_store_data), .resp_valid(resp_valid), .resp_load_data(resp_load_data),
    .resp_fault(resp_fault), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_address(mem_address), .mem_frame_mask(mem_frame_mask), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data));

  load_store_unit_split #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_dut_strict (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_address(req_address),
    .req_store_data(req_store_data), .resp_valid(resp_valid2), .resp_load_data(resp_load_data2),
    .resp_fault(resp_fault2), .mem_valid(mem_valid2), .mem_ready(mem_ready), .mem_write(mem_write2),
    .mem_address(mem_address2), .mem_frame_mask(mem_frame_mask2), .mem_write_data(mem_write_data2),
    .mem_read_data(mem_read_data));

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wd;
    logic [31:0] rd;
  } beat_t;

  typedef struct {
    logic        fault;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  beat_t exp_beat[$];
  resp_t exp_resp[$];
  resp_t exp_resp2[$];
  beat_t mon_b;
  resp_t mon_r, mon_r2;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder and scoreboard monitors, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (mem_valid) begin
      if (exp_beat.size() == 0) begin
        check("unexpected beat", mem_valid, 1'b0);
      end else begin
        mon_b = exp_beat[0];
        check("beat addr", mem_address, mon_b.addr);
        check("beat mask", mem_frame_mask, mon_b.mask);
        check("beat write", mem_write, mon_b.w);
        if (mon_b.w) check("beat wdata", mem_write_data, mon_b.wd);
        mem_read_data = mon_b.rd;
        if (mem_ready) void'(exp_beat.pop_front());
      end
    end
    if (resp_valid) begin
      if (exp_resp.size() == 0) begin
        check("unexpected resp", resp_valid, 1'b0);
      end else begin
        mon_r = exp_resp.pop_front();
        check("resp fault", resp_fault, mon_r.fault);
        check("resp data", resp_load_data, mon_r.data);
        check("resp cycle", cyc, mon_r.cyc);
        check("req_ready in RESP", req_ready, 1'b0);
      end
    end
    if (mem_valid2) check("strict unit bus", mem_valid2, 1'b0);
    if (resp_valid2) begin
      if (exp_resp2.size() == 0) begin
        check("strict unexpected resp", resp_valid2, 1'b0);
      end else begin
        mon_r2 = exp_resp2.pop_front();
        check("strict resp fault", resp_fault2, mon_r2.fault);
        check("strict resp data", resp_load_data2, mon_r2.data);
        check("strict resp cycle", cyc, mon_r2.cyc);
      end
    end
  end

  task automatic push_beat(input logic w, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] wd, input logic [31:0] rd);
    beat_t b;
    b.w = w; b.addr = a; b.mask = m; b.wd = wd; b.rd = rd;
    exp_beat.push_back(b);
  endtask

  // Called at a negedge with the target unit idle; lat counts cycles from acceptance.
  task automatic issue(input bit strict, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input bit exp_r,
                       input logic fault, input logic [31:0] data, input int lat);
    resp_t r;
    r.fault = fault; r.data = data; r.cyc = cyc + lat;
    if (exp_r) begin
      if (strict) exp_resp2.push_back(r);
      else exp_resp.push_back(r);
    end
    req_opcode = opc; req_funct3 = f3; req_address = a; req_store_data = sd;
    if (strict) req_valid2 = 1'b1;
    else req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_valid2 = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 40;
    while ((exp_resp.size() + exp_resp2.size() + exp_beat.size()) != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("timeout pending", exp_resp.size() + exp_resp2.size() + exp_beat.size(), 0);
      exp_resp.delete(); exp_resp2.delete(); exp_beat.delete();
    end
    @(negedge clk);
    check("req_ready idle", req_ready, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("reset req_ready", req_ready, 1'b1);
    check("reset mem_valid", mem_valid, 1'b0);
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset load_data", resp_load_data, 32'h0);
    check("reset mem_address", mem_address, 32'h0);
    check("reset mask", mem_frame_mask, 4'h0);
    check("reset strict req_ready", req_ready2, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Aligned word store
    push_beat(1'b1, 32'h100, 4'b1111, 32'h11223344, 32'h0);
    issue(0, c_STORE, c_WORD, 32'h100, 32'h11223344, 1, 1'b0, 32'h0, 2);
    wait_done();

    // Byte loads, signed and unsigned
    push_beat(1'b0, 32'h200, 4'b1000, 32'h0, 32'h80FFFFFF);
    issue(0, c_LOAD, c_BYTE, 32'h203, 32'h0, 1, 1'b0, 32'hFFFFFF80, 2);
    wait_done();
    push_beat(1'b0, 32'h200, 4'b1000, 32'h0, 32'h80FFFFFF);
    issue(0, c_LOAD, c_BYTE_UNSIGNED, 32'h203, 32'h0, 1, 1'b0, 32'h00000080, 2);
    wait_done();

    // Split word load
    push_beat(1'b0, 32'h100, 4'b1100, 32'h0, 32'hBBBB1234);
    push_beat(1'b0, 32'h104, 4'b0011, 32'h0, 32'h5678AAAA);
    issue(0, c_LOAD, c_WORD, 32'h102, 32'h0, 1, 1'b0, 32'hAAAABBBB, 3);
    wait_done();

    // Split halfword store; upper store bits must not leak
    push_beat(1'b1, 32'h100, 4'b1000, 32'hEF000000, 32'h0);
    push_beat(1'b1, 32'h104, 4'b0001, 32'h000000BE, 32'h0);
    issue(0, c_STORE, c_HALFWORD, 32'h103, 32'h1234BEEF, 1, 1'b0, 32'h0, 3);
    wait_done();

    // Split unsigned halfword load
    push_beat(1'b0, 32'h100, 4'b1000, 32'h0, 32'h9A000000);
    push_beat(1'b0, 32'h104, 4'b0001, 32'h0, 32'h000000F1);
    issue(0, c_LOAD, c_HALFWORD_UNSIGNED, 32'h103, 32'h0, 1, 1'b0, 32'h0000F19A, 3);
    wait_done();

    // Aligned signed halfword in upper lanes
    push_beat(1'b0, 32'h104, 4'b1100, 32'h0, 32'h80011234);
    issue(0, c_LOAD, c_HALFWORD, 32'h106, 32'h0, 1, 1'b0, 32'hFFFF8001, 2);
    wait_done();

    // Misaligned but not crossing: one beat
    push_beat(1'b0, 32'h100, 4'b0110, 32'h0, 32'h00ABCD00);
    issue(0, c_LOAD, c_HALFWORD, 32'h101, 32'h0, 1, 1'b0, 32'hFFFFABCD, 2);
    wait_done();

    // Byte store
    push_beat(1'b1, 32'h100, 4'b0010, 32'h0000A500, 32'h0);
    issue(0, c_STORE, c_BYTE, 32'h101, 32'hFFFFFFA5, 1, 1'b0, 32'h0, 2);
    wait_done();

    // Split load wrapping past the top of the address space
    push_beat(1'b0, 32'hFFFFFFFC, 4'b1100, 32'h0, 32'h33440000);
    push_beat(1'b0, 32'h00000000, 4'b0011, 32'h0, 32'h00002211);
    issue(0, c_LOAD, c_WORD, 32'hFFFFFFFE, 32'h0, 1, 1'b0, 32'h22113344, 3);
    wait_done();

    // Two bus wait cycles
    push_beat(1'b0, 32'h300, 4'b1111, 32'h0, 32'hCAFEF00D);
    mem_ready = 1'b0;
    issue(0, c_LOAD, c_WORD, 32'h300, 32'h0, 1, 1'b0, 32'hCAFEF00D, 4);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    wait_done();

    // Illegal encodings fault without bus traffic
    issue(0, c_LOAD, 3'b111, 32'h100, 32'h0, 1, 1'b1, 32'h0, 1);
    wait_done();
    issue(0, 7'h33, c_WORD, 32'h100, 32'h0, 1, 1'b1, 32'h0, 1);
    wait_done();
    issue(0, c_LOAD, c_DOUBLEWORD, 32'h100, 32'h0, 1, 1'b1, 32'h0, 1);
    wait_done();
    issue(0, c_LOAD, c_WORD_UNSIGNED, 32'h100, 32'h0, 1, 1'b1, 32'h0, 1);
    wait_done();

    // Misaligned with splitting disabled
    issue(1, c_LOAD, c_HALFWORD, 32'h101, 32'h0, 1, 1'b1, 32'h0, 1);
    wait_done();
    check("strict req_ready idle", req_ready2, 1'b1);

    // Stalled store abandoned by reset
    push_beat(1'b1, 32'h200, 4'b1111, 32'hDEADBEEF, 32'h0);
    mem_ready = 1'b0;
    issue(0, c_STORE, c_WORD, 32'h200, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abandoned beat still pending", exp_beat.size(), 1);
    exp_beat.delete();
    #2;
    check("post-reset mem_valid", mem_valid, 1'b0);
    check("post-reset req_ready", req_ready, 1'b1);
    check("post-reset resp_valid", resp_valid, 1'b0);
    check("post-reset mask", mem_frame_mask, 4'h0);
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post-reset idle", req_ready, 1'b1);
    check("leftover responses", exp_resp.size() + exp_resp2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
